ras_ctrl: RTL
=============

Name: ras_ctrl

Overview:
Return-address-stack controller that sits between the fetch/branch unit and a simple dual-port BRAM with one cycle of read latency.
- Accepts push (call) and pop (return) requests through valid/ready handshakes.
- Keeps the top-of-stack (TOS) entry in a register and stores the full stack in the BRAM.
- Drives the BRAM's read/write request ports and consumes its registered read data.
- Port A is used for writes only; port B is used for reads only.

Parameters:
DEPTH, 1024, number of stack entries; must be a power of 2 and match the attached BRAM.
WIDTH, 36, width of a return-address entry; must match the attached BRAM.
ADDR, $clog2(DEPTH), localparam; BRAM address width.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst_n  in  1  asynchronous active-low reset.
push_valid  in  1  push request.
push_ready  out  1  push can be accepted.
push_data  in  WIDTH  return address to push.
pop_valid  in  1  pop request.
pop_ready  out  1  pop can be accepted.
pop_rsp_valid  out  1  popped data valid (one-cycle pulse).
pop_rsp_data  out  WIDTH  popped return address.
count  out  ADDR+1  number of valid entries, 0..DEPTH.
empty  out  1  count==0.
full  out  1  count==DEPTH.
mem_rea, mem_wea, mem_reb, mem_web  out  1 each  BRAM enables; mem_rea=0 and mem_web=0 always.
mem_raddra, mem_waddra, mem_raddrb, mem_waddrb  out  ADDR each  BRAM addresses; mem_raddra=0 and mem_waddrb=0 always.
mem_wia, mem_wib  out  WIDTH each  BRAM write data; mem_wib=0 always.
mem_doa  in  WIDTH  unused.
mem_dob  in  WIDTH  port-B read data, valid the cycle after mem_reb.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, wptr=0, count=0, tos=0.
  - pop_rsp_valid=0, pop_rsp_data=0.
  - All mem_* enables are 0.
  - BRAM contents are not cleared.
- Fire definitions: push_fire = push_valid & push_ready; pop_fire = pop_valid & pop_ready.
- wptr is the next BRAM write index. All index arithmetic is modulo DEPTH (ADDR bits, natural wrap).
- The BRAM request outputs are combinational from the fire signals, so the BRAM samples them at the same edge the controller updates its own state.
- States:
  - IDLE: push_ready = !full (see Optional Feature); pop_ready = !empty.
  - REFILL: lasts exactly 1 cycle. push_ready=0, pop_ready=0. tos <= mem_dob. Always returns to IDLE.
- Push only (IDLE, push_fire, !pop_fire):
  - mem_wea=1, mem_waddra=wptr, mem_wia=push_data.
  - tos <= push_data; wptr++; count++.
- Pop only (IDLE, pop_fire, !push_fire):
  - Next cycle: pop_rsp_valid=1, pop_rsp_data = tos as sampled at the fire edge.
  - wptr--; count--.
  - If count>=2 at fire: mem_reb=1, mem_raddrb=wptr-2, next state=REFILL.
  - If count==1 at fire: no read; stay in IDLE; the stack becomes empty.
- Simultaneous push+pop (IDLE, both fire; requires count>=1):
  - Operation is a TOS replace: pop response = old tos, next cycle.
  - mem_wea=1, mem_waddra=wptr-1, mem_wia=push_data.
  - tos <= push_data; wptr and count unchanged; no REFILL.
  - Allowed when full, even without RAS_WRAP_EN.
- Push while empty with pop_valid=1: pop_ready=0, so only the push fires.
- pop_rsp_valid is a single-cycle pulse. There is no backpressure on the response.
- Reset asserted during REFILL: controller aborts to IDLE with empty stack; mem_dob is ignored.
- tos and BRAM[wptr-1] always hold the same value when count>0.

Optional Feature:
Macro: RAS_WRAP_EN.
- Defined (circular overflow):
  - push_ready ignores full.
  - A push-only when full writes mem[wptr], tos <= push_data, wptr++, count stays DEPTH. The oldest entry is silently overwritten.
  - Subsequent pops return entries newest-first; after DEPTH pops the stack reports empty.
- Undefined: push_ready=0 while full and state==IDLE, unless pop_valid=1 with count>=1, which is the replace case.

Test Plan:
- Ordering: push 0x100, 0x200, 0x300 back-to-back, then pop three times:
  - responses are 0x300, 0x200, 0x100;
  - pop_ready=0 for exactly one cycle after the first and second pops;
  - no REFILL after the third pop; empty=1, count=0.
- Replace: push 0xA, then same-cycle push 0xB + pop:
  - response 0xA; count stays 1;
  - a following pop returns 0xB with no REFILL;
  - mem_waddra=0 on the replace cycle.
- Full without RAS_WRAP_EN: push DEPTH entries (value=index):
  - full=1, push_ready=0;
  - a push+pop together is still accepted and returns DEPTH-1.
- Wrap with RAS_WRAP_EN, DEPTH=4: push 1..6, then pop 4 times:
  - returns 6, 5, 4, 3; empty=1 afterwards; count never exceeds 4.
- Empty pop: pop_valid=1 from reset:
  - pop_ready=0; no pop_rsp_valid; no mem_reb.
- Reset mid-REFILL: push 2 entries, pop, then drop rst_n during the REFILL cycle:
  - after release: state IDLE, count=0, pop_rsp_valid=0, push_ready=1.

Source files
------------

// File: rtl/ras_ctrl.sv
// Return-address stack: TOS held in a register, full stack mirrored in a 1-cycle-latency BRAM.
// Optional macro RAS_WRAP_EN: pushes accepted while full overwrite the oldest entry.
module ras_ctrl #(
    parameter  int DEPTH = 1024,
    parameter  int WIDTH = 36,
    localparam int ADDR  = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             push_valid,
    output logic             push_ready,
    input  logic [WIDTH-1:0] push_data,

    input  logic             pop_valid,
    output logic             pop_ready,
    output logic             pop_rsp_valid,
    output logic [WIDTH-1:0] pop_rsp_data,

    output logic [ADDR:0]    count,
    output logic             empty,
    output logic             full,

    output logic             mem_rea,
    output logic             mem_wea,
    output logic             mem_reb,
    output logic             mem_web,
    output logic [ADDR-1:0]  mem_raddra,
    output logic [ADDR-1:0]  mem_waddra,
    output logic [ADDR-1:0]  mem_raddrb,
    output logic [ADDR-1:0]  mem_waddrb,
    output logic [WIDTH-1:0] mem_wia,
    output logic [WIDTH-1:0] mem_wib,
    input  logic [WIDTH-1:0] mem_doa,
    input  logic [WIDTH-1:0] mem_dob
);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_REFILL = 1'b1
    } state_t;

    localparam logic [ADDR:0] C_FULL = (ADDR+1)'(DEPTH);
    localparam logic [ADDR:0] C_TWO  = (ADDR+1)'(2);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ADDR-1:0]    r_wptr;
    logic [ADDR:0]      r_count;
    logic [WIDTH-1:0]   r_tos;
    logic               r_rsp_valid;
    logic [WIDTH-1:0]   r_rsp_data;

    logic               w_idle;
    logic               w_full;
    logic               w_empty;
    logic               w_push_fire;
    logic               w_pop_fire;
    logic               w_push_only;
    logic               w_pop_only;
    logic               w_refill_req;
    logic               w_unused_doa;

    assign w_idle  = (r_state == S_IDLE);
    assign w_full  = (r_count == C_FULL);
    assign w_empty = (r_count == '0);

`ifdef RAS_WRAP_EN
    assign push_ready = w_idle;
`else
    // While full, a push is only taken as the push half of a TOS replace.
    assign push_ready = w_idle & (!w_full | (pop_valid & !w_empty));
`endif
    assign pop_ready = w_idle & !w_empty;

    assign w_push_fire  = push_valid & push_ready;
    assign w_pop_fire   = pop_valid & pop_ready;
    assign w_push_only  = w_push_fire & !w_pop_fire;
    assign w_pop_only   = w_pop_fire & !w_push_fire;
    assign w_refill_req = w_pop_only & (r_count >= C_TWO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // BRAM requests are combinational so the BRAM samples them on the same edge as our state update.
    always_comb begin
        w_state_nxt = r_state;
        mem_wea     = 1'b0;
        mem_waddra  = '0;
        mem_wia     = '0;
        mem_reb     = 1'b0;
        mem_raddrb  = '0;
        unique case (r_state)
            S_IDLE: begin
                if (w_push_fire) begin
                    mem_wea    = 1'b1;
                    mem_waddra = w_pop_fire ? (r_wptr - 1'b1) : r_wptr;
                    mem_wia    = push_data;
                end
                if (w_refill_req) begin
                    mem_reb     = 1'b1;
                    mem_raddrb  = r_wptr - ADDR'(2);
                    w_state_nxt = S_REFILL;
                end
            end
            S_REFILL: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr      <= '0;
            r_count     <= '0;
            r_tos       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_rsp_valid <= w_pop_fire;
            if (w_pop_fire) begin
                r_rsp_data <= r_tos;
            end

            if (r_state == S_REFILL) begin
                r_tos <= mem_dob;
            end else if (w_push_fire) begin
                r_tos <= push_data;
            end

            // A push while full only happens in wrap mode; the count saturates at DEPTH.
            if (w_push_only) begin
                r_wptr <= r_wptr + 1'b1;
                if (!w_full) begin
                    r_count <= r_count + 1'b1;
                end
            end else if (w_pop_only) begin
                r_wptr  <= r_wptr - 1'b1;
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign pop_rsp_valid = r_rsp_valid;
    assign pop_rsp_data  = r_rsp_data;
    assign count         = r_count;
    assign empty         = w_empty;
    assign full          = w_full;

    assign mem_rea    = 1'b0;
    assign mem_web    = 1'b0;
    assign mem_raddra = '0;
    assign mem_waddrb = '0;
    assign mem_wib    = '0;

    assign w_unused_doa = ^mem_doa;

endmodule
